vga_top: RTL and testbench
==========================

Name: vga_top

Overview:
- Self-starting display subsystem for 640x480@60 VGA.
- After reset, a fixed boot sequencer issues two store transactions on an internal bus. The first writes a colour register at byte address 96; the second writes a channel-enable register at address 100.
- A VGA timing generator paints the visible area with the masked colour.
- The store bus (MemWrite, DataAdr, WriteData) is exported so a bench can monitor the boot writes.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 4, clk cycles per pixel (100 MHz clk gives 25 MHz pixel rate)
- COLOR_ADR, 96, byte address of colour register
- MODE_ADR, 100, byte address of channel-enable register

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- MemWrite  out  1  store strobe; 1 = DataAdr/WriteData valid this cycle
- DataAdr  out  32  store byte address
- WriteData  out  32  store data
- VGA_R  out  4  red
- VGA_G  out  4  green
- VGA_B  out  4  blue
- VGA_HS_O  out  1  hsync, active-low
- VGA_VS_O  out  1  vsync, active-low

Behaviour:
- Reset asserted (reset=0): all regs clear immediately.
  - MemWrite=0, DataAdr=0, WriteData=0.
  - color_reg=0, mode_reg=0, counters=0.
  - VGA_R/G/B=0, VGA_HS_O=1, VGA_VS_O=1.
  - Sequencer state = BOOT.
- Boot sequencer is a Moore FSM with registered state:
  - BOOT -> W_COLOR on the first rising edge with reset=1.
  - W_COLOR outputs MemWrite=1, DataAdr=96, WriteData=32'h0000_0FFF.
  - W_COLOR -> W_MODE unconditionally.
  - W_MODE outputs MemWrite=1, DataAdr=100, WriteData=32'h0000_0007.
  - W_MODE -> DONE unconditionally.
  - BOOT and DONE output MemWrite=0, DataAdr=0, WriteData=0.
  - DONE is terminal until the next reset.
- Exactly two store cycles per reset; the last store is always address 100 with data 7. No store to any address other than 96 or 100 may ever occur.
- Register file: at a rising edge with MemWrite=1:
  - DataAdr==COLOR_ADR loads color_reg <= WriteData[11:0] (R=[11:8], G=[7:4], B=[3:0]).
  - DataAdr==MODE_ADR loads mode_reg <= WriteData[2:0] (bit2=R en, bit1=G en, bit0=B en).
  - Any other address: no effect.
- Pixel enable:
  - A free-running divider counts 0..PIX_DIV-1 and asserts pix_en when it reaches PIX_DIV-1.
  - The divider starts counting on the first clock after reset release.
- Timing counters (advance only on pix_en):
  - hcnt runs 0..799 and wraps to 0.
  - On hcnt wrap, vcnt increments, running 0..524 and wrapping to 0.
- Sync (active-low):
  - hsync active when H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC (656..751).
  - vsync active when 490 <= vcnt < 492.
- Video:
  - visible = (hcnt<640) && (vcnt<480).
  - When visible: VGA_R = mode_reg[2] ? color_reg[11:8] : 0; G and B follow the same rule.
  - Outside visible: RGB = 0.
- Output latency: RGB and sync outputs are registered, one clk after the counter values they reflect.
- Reset asserted mid-frame or mid-sequence: everything returns to reset values asynchronously. On release the boot sequence and the frame both restart from 0.
- Register writes landing mid-frame take effect on the next pixel; there is no frame-boundary latching.

Test Plan:
- Hold reset=0 for 2 cycles -> MemWrite=0, all RGB=0, VGA_HS_O=VGA_VS_O=1. Release reset -> MemWrite=1 on cycles 2 and 3 after release, else 0.
- Monitor the store bus at each negedge with MemWrite=1 -> first (96, 0xFFF), then (100, 7). No other address appears, and MemWrite stays 0 afterwards for 10000 cycles.
- After boot, sample the first visible pixel (hcnt=0, vcnt=0) -> RGB = F,F,F. At hcnt=640 -> RGB=0.
- Measure sync timing -> hsync low for 96 pixels (384 clk) every 800 pixels (3200 clk); vsync low for 2 lines (6400 clk) every 525 lines.
- Force mode_reg=3'b010 via a bench-side write -> visible pixels R=0, G=F, B=0.
- Pulse reset low mid-frame -> outputs return to reset values immediately, and both store cycles are reissued after release.

Source files
------------

// File: rtl/vga_top_if.sv
// Store bus bundle: one-cycle write strobe with byte address and data.
interface vga_top_if;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wdata;

  modport master (output we, adr, wdata);
  modport slave  (input  we, adr, wdata);
endinterface

// File: rtl/vga_top.sv
// Self-starting 640x480@60 VGA subsystem: a boot sequencer stores a colour
// and a channel-enable word over the internal store bus, and the timing
// generator paints the visible area with the masked colour.
module vga_top #(
  parameter int unsigned H_VIS     = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VIS     = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned PIX_DIV   = 4,
  parameter int unsigned COLOR_ADR = 96,
  parameter int unsigned MODE_ADR  = 100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        MemWrite,
  output logic [31:0] DataAdr,
  output logic [31:0] WriteData,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS_O,
  output logic        VGA_VS_O
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C   = HW'(H_VIS);
  localparam logic [VW-1:0] V_VIS_C   = VW'(V_VIS);
  localparam logic [HW-1:0] HS_START  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST  = DW'(PIX_DIV - 1);

  typedef enum logic [1:0] {BOOT, W_COLOR, W_MODE, DONE} boot_state_t;

  vga_top_if bus ();

  boot_state_t     state_q;
  logic            we_q;
  logic [31:0]     adr_q;
  logic [31:0]     wdata_q;
  logic [11:0]     color_q;
  logic [2:0]      mode_q;
  logic [DW-1:0]   div_q, div_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  logic            pix_en;
  logic            visible, hs_act, vs_act;
  logic [3:0]      r_q, g_q, b_q;
  logic            hs_q, vs_q;
  logic            unused_wdata;

  assign bus.we    = we_q;
  assign bus.adr   = adr_q;
  assign bus.wdata = wdata_q;

  assign MemWrite  = we_q;
  assign DataAdr   = adr_q;
  assign WriteData = wdata_q;

  assign unused_wdata = ^bus.wdata[31:12];

  // Boot sequencer: bus outputs are registered with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= W_COLOR;
          we_q    <= 1'b1;
          adr_q   <= 32'(COLOR_ADR);
          wdata_q <= 32'h0000_0FFF;
        end
        W_COLOR: begin
          state_q <= W_MODE;
          we_q    <= 1'b1;
          adr_q   <= 32'(MODE_ADR);
          wdata_q <= 32'h0000_0007;
        end
        default: begin
          state_q <= DONE;
          we_q    <= 1'b0;
          adr_q   <= '0;
          wdata_q <= '0;
        end
      endcase
    end
  end

  // Colour and channel-enable registers decoded from the store bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color_q <= '0;
      mode_q  <= '0;
    end else if (bus.we) begin
      if (bus.adr == 32'(COLOR_ADR)) begin
        color_q <= bus.wdata[11:0];
      end else if (bus.adr == 32'(MODE_ADR)) begin
        mode_q <= bus.wdata[2:0];
      end
    end
  end

  // Pixel divider and raster counters next-state.
  always_comb begin
    pix_en = (div_q == DIV_LAST);
    div_d  = pix_en ? '0 : div_q + 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Region decode from the current counter values.
  always_comb begin
    visible = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
    hs_act  = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    vs_act  = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
  end

  // Registered video and sync outputs, one clock behind the counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      r_q  <= (visible && mode_q[2]) ? color_q[11:8] : 4'h0;
      g_q  <= (visible && mode_q[1]) ? color_q[7:4]  : 4'h0;
      b_q  <= (visible && mode_q[0]) ? color_q[3:0]  : 4'h0;
      hs_q <= ~hs_act;
      vs_q <= ~vs_act;
    end
  end

  assign VGA_R    = r_q;
  assign VGA_G    = g_q;
  assign VGA_B    = b_q;
  assign VGA_HS_O = hs_q;
  assign VGA_VS_O = vs_q;

endmodule

// File: tb/tb_vga_top.sv
// Randomized self-checking bench for vga_top against a time-indexed model.
// Vertical timing is shortened so a whole frame fits in a short run.
module tb_vga_top;

  localparam longint H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam longint V_VIS = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam longint PIX_DIV = 4;
  localparam longint H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam longint V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam longint FRAME = H_TOT * V_TOT * PIX_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite;
  logic [31:0] DataAdr, WriteData;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS_O, VGA_VS_O;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned store_cnt = 0;
  longint      n = 0;
  longint      mode_switch_n = 64'h7fff_ffff_ffff;
  logic        prev_hs = 1'b1, prev_vs = 1'b1;
  longint      hs_fall = 0, vs_fall = 0;

  vga_top_if mon ();
  assign mon.we    = MemWrite;
  assign mon.adr   = DataAdr;
  assign mon.wdata = WriteData;

  vga_top #(
    .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIX_DIV(4), .COLOR_ADR(96), .MODE_ADR(100)
  ) dut (
    .clk(clk), .reset(reset),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS_O(VGA_HS_O), .VGA_VS_O(VGA_VS_O)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (edge %0d)", tag, act, exp, n);
    end
  endtask

  // Expected outputs k edges after reset release (k=0: still in reset).
  task automatic model(input longint k, output logic [64:0] bus_e, output logic [13:0] vid_e);
    longint m, p, h, v;
    logic [11:0] col;
    logic [2:0]  md;
    logic        vis;
    logic [3:0]  r, g, b;
    if (k == 1)      bus_e = {1'b1, 32'd96,  32'h0000_0FFF};
    else if (k == 2) bus_e = {1'b1, 32'd100, 32'h0000_0007};
    else             bus_e = '0;
    if (k == 0) begin
      vid_e = {12'h000, 1'b1, 1'b1};
    end else begin
      m   = k - 1;
      p   = m / PIX_DIV;
      h   = p % H_TOT;
      v   = (p / H_TOT) % V_TOT;
      col = (k >= 3) ? 12'hFFF : 12'h000;
      md  = (k < 4) ? 3'b000 : ((k >= mode_switch_n) ? 3'b010 : 3'b111);
      vis = (h < H_VIS) && (v < V_VIS);
      r   = (vis && md[2]) ? col[11:8] : 4'h0;
      g   = (vis && md[1]) ? col[7:4]  : 4'h0;
      b   = (vis && md[0]) ? col[3:0]  : 4'h0;
      vid_e = {r, g, b,
               !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC),
               !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC)};
    end
  endtask

  task automatic compare_now(input longint k);
    logic [64:0] be;
    logic [13:0] ve;
    model(k, be, ve);
    check_eq("bus", {15'b0, MemWrite, DataAdr, WriteData}, {15'b0, be});
    check_eq("video", {66'b0, VGA_R, VGA_G, VGA_B, VGA_HS_O, VGA_VS_O}, {66'b0, ve});
  endtask

  task automatic run_cycles(input longint cnt);
    for (longint i = 0; i < cnt; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      compare_now(n);
      if (mon.we) begin
        store_cnt++;
        check_eq("store_adr_legal", 80'(mon.adr == 32'd96 || mon.adr == 32'd100), 80'd1);
      end
      if (n == 4)
        check_eq("first_pixel", {68'b0, VGA_R, VGA_G, VGA_B}, {68'b0, 12'hFFF});
      if (n == H_VIS * PIX_DIV + 1)
        check_eq("h640_black", {68'b0, VGA_R, VGA_G, VGA_B}, 80'd0);
      if (prev_hs && !VGA_HS_O) begin
        if (hs_fall != 0) check_eq("hs_period", 80'(n - hs_fall), 80'(H_TOT * PIX_DIV));
        hs_fall = n;
      end
      if (!prev_hs && VGA_HS_O && hs_fall != 0)
        check_eq("hs_width", 80'(n - hs_fall), 80'(H_SYNC * PIX_DIV));
      if (prev_vs && !VGA_VS_O) vs_fall = n;
      if (!prev_vs && VGA_VS_O && vs_fall != 0)
        check_eq("vs_width", 80'(n - vs_fall), 80'(V_SYNC * H_TOT * PIX_DIV));
      prev_hs = VGA_HS_O;
      prev_vs = VGA_VS_O;
    end
  endtask

  // Release reset at a negedge and restart the edge index and trackers.
  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    store_cnt = 0;
    mode_switch_n = 64'h7fff_ffff_ffff;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    hs_fall = 0;
    vs_fall = 0;
  endtask

  task automatic hold_reset_cycles(input int unsigned cnt);
    for (int unsigned i = 0; i < cnt; i++) begin
      @(posedge clk);
      @(negedge clk);
      compare_now(0);
    end
  endtask

  initial begin
    longint extra, base, target;
    longint line_sel, pix_sel;

    #1 reset = 1'b0;
    hold_reset_cycles(2);

    // Boot and one full frame.
    release_reset();
    run_cycles(FRAME + 8);
    check_eq("boot_store_count", 80'(store_cnt), 80'd2);

    // Random gap, then override the channel enables to green only.
    extra = longint'($urandom_range(1000, 0));
    run_cycles(extra);
    force dut.mode_q = 3'b010;
    mode_switch_n = n + 1;
    run_cycles(H_TOT * PIX_DIV);
    release dut.mode_q;

    // Async reset at a random visible pixel in lines 2..3 of the frame.
    line_sel = longint'($urandom_range(3, 2));
    pix_sel  = longint'($urandom_range(639, 0));
    base     = (n / FRAME) * FRAME;
    target   = base + (line_sel * H_TOT + pix_sel) * PIX_DIV + 2;
    if (target <= n) target = target + FRAME;
    run_cycles(target - n);
    #1 reset = 1'b0;
    #1;
    check_eq("async_reset_bus", {15'b0, MemWrite, DataAdr, WriteData}, 80'd0);
    check_eq("async_reset_video", {66'b0, VGA_R, VGA_G, VGA_B, VGA_HS_O, VGA_VS_O},
             {66'b0, 12'h000, 1'b1, 1'b1});
    hold_reset_cycles(2);
    release_reset();
    run_cycles(H_TOT * PIX_DIV + 16);
    check_eq("reboot_store_count", 80'(store_cnt), 80'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
